// File: rtl/pwm_capture.sv
// PWM period / high-time capture: synchronizes pwm_in, measures rise-to-fall and
// rise-to-rise times in sys_clk cycles, and flags a static input after a timeout.
module pwm_capture #(
    parameter int               CNT_W       = 20,
    parameter logic [CNT_W-1:0] TIMEOUT_MAX = 20'd200000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             no_signal,
    output logic             static_level
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hold_high;
    logic [CNT_W-1:0] cnt_inc;
    logic             rise, fall;
    logic             timeout;

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    // Saturating increment: a fall landing on the timeout cycle must not let cnt wrap in LOW.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    assign timeout = (cnt >= TIMEOUT_MAX);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            hold_high    <= '0;
            high_cnt     <= '0;
            period_cnt   <= '0;
            meas_valid   <= 1'b0;
            no_signal    <= 1'b1;
            static_level <= 1'b0;
        end else begin
            s1         <= pwm_in;
            s2         <= s1;
            s3         <= s2;
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (fall) begin
                        hold_high <= cnt;
                        cnt       <= cnt_inc;
                        state     <= LOW;
                    end else if (timeout) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        no_signal    <= 1'b1;
                        static_level <= s2;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                LOW: begin
                    // An edge on the timeout cycle still closes the period normally.
                    if (rise) begin
                        high_cnt   <= hold_high;
                        period_cnt <= cnt;
                        meas_valid <= 1'b1;
                        no_signal  <= 1'b0;
                        cnt        <= CNT_W'(1);
                        state      <= HIGH;
                    end else if (timeout) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        no_signal    <= 1'b1;
                        static_level <= s2;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 20: width of the cycle counters and of the measurement outputs.
REQ-002 Parameter TIMEOUT_MAX, default 20'd200000: cycles without a detected edge before the input is declared static; legal range 2 to 2^CNT_W-1.
REQ-003 sys_clk  input  1  system clock; all logic on the rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pwm_in  input  1  asynchronous PWM input, e.g. the breathing-LED drive.
REQ-006 high_cnt  output  CNT_W  high time of the last complete period, in sys_clk cycles.
REQ-007 period_cnt  output  CNT_W  rising-to-rising time of the last complete period, in sys_clk cycles.
REQ-008 meas_valid  output  1  one-cycle pulse; high_cnt and period_cnt are updated in the same cycle.
REQ-009 no_signal  output  1  level; high while no valid periodic input is present.
REQ-010 static_level  output  1  synchronized pwm_in level latched when a timeout occurs.

Function
REQ-011 pwm_in SHALL pass through a 2-flop synchronizer (s1, s2), followed by a delay flop s3.
- rise = s2 & ~s3; fall = ~s2 & s3; both are combinational.
REQ-012 The block SHALL implement three states: IDLE, HIGH and LOW.
REQ-013 IDLE: on rise, go to HIGH and load cnt to 1; fall is ignored; cnt is held at 0.
REQ-014 HIGH: cnt increments by 1 per cycle; on fall, capture hold_high <= cnt and go to LOW.
REQ-015 LOW: cnt increments; on rise, the following SHALL happen together:
- high_cnt <= hold_high; period_cnt <= cnt
- meas_valid = 1; no_signal <= 0
- cnt <= 1; stay in HIGH (go to HIGH).
REQ-016 Resulting values: high_cnt = (fall cycle - rise cycle) and period_cnt = (next rise cycle - rise cycle), exactly, with no +/-1 error.
REQ-017 Measurement latency: meas_valid SHALL be registered, so it is high in the 3rd cycle after the first sys_clk edge that samples pwm_in high.
REQ-018 Timeout: in HIGH or LOW, if cnt == TIMEOUT_MAX and no edge occurs in that cycle:
- go to IDLE; cnt <= 0
- no_signal <= 1; static_level <= s2
- meas_valid stays 0.
REQ-019 Simultaneous events: an edge in the same cycle as the timeout condition SHALL take priority; timeout is not taken.
REQ-020 cnt SHALL never wrap; TIMEOUT_MAX < 2^CNT_W guarantees this.
REQ-021 After a timeout, the first rise starts a new measurement; the first meas_valid follows the second rise.
REQ-022 high_cnt, period_cnt and static_level SHALL hold their values between updates; they are not cleared on timeout.
REQ-023 meas_valid SHALL never be high in two consecutive cycles.
REQ-024 Pulses shorter than 2 sys_clk cycles at the input may be missed; the block SHALL NOT produce corrupted counts from them (any missed pulse simply does not occur in the edge stream).

Reset
REQ-025 While sys_rst_n = 0:
- s1, s2, s3 = 0; state = IDLE; cnt = 0; hold_high = 0
- high_cnt = 0; period_cnt = 0; meas_valid = 0; static_level = 0; no_signal = 1.
REQ-026 Reset asserted mid-measurement SHALL discard the partial period; after release, measurement restarts from IDLE as in REQ-021.

Verification (CNT_W=16, TIMEOUT_MAX=1000)
REQ-027 pwm_in 30 cycles high / 70 low, repeated:
- no meas_valid after the first rise
- every later period: high_cnt=30, period_cnt=100, exactly one meas_valid per 100 cycles; no_signal 1 -> 0 at the first meas_valid.
REQ-028 Duty sweep 1/100 up to 99/100 at period 100:
- each meas_valid reports high_cnt equal to the driven high time and period_cnt=100.
REQ-029 pwm_in held at 1 after a valid stream:
- 1000 cycles after the last rise, no_signal=1 and static_level=1
- high_cnt and period_cnt keep their last values.
- Repeat with pwm_in held at 0: static_level=0.
REQ-030 Reset pulse 50 cycles into a period:
- all outputs at REQ-025 values
- after release, the first meas_valid follows the second full rise with correct counts.
REQ-031 Edge/timeout collision: force a rise exactly in the cycle where cnt == 1000:
- meas_valid=1 with period_cnt=1000; no_signal stays 0.
REQ-032 Random-phase asynchronous pwm_in with period 50 +/- 0 and high 20:
- every meas_valid reports period_cnt=50 and high_cnt in 19..21 (sync jitter), never 0.
